// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the shared adder arbiter.
// Optional build macro: ADDER_SATURATE_EN (saturating result).
package adder_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int REQ_N  = 3;
    localparam int ID_W   = $clog2(REQ_N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic [ID_W-1:0]   id;
        logic              cout;
        logic              ovfl;
    } adder_rsp_t;

    // Largest positive signed value of width w.
    function automatic logic [63:0] SAT_POS(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative signed value of width w.
    function automatic logic [63:0] SAT_NEG(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between requesters, consumer and the shared adder.
// master: requesters + consumer side; slave: the arbiter.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 16
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic [IDW-1:0]           rsp_id;
    logic                     rsp_cout;
    logic                     rsp_ovfl;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_cout, rsp_ovfl
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_cout, rsp_ovfl
    );

endinterface

// File: rtl/adder_share_arbiter_datapath.sv
// Combinational add/subtract: chained 4-bit CLA slices, overflow detect.
// Ports: a, b, sub in; sum, cout, ovfl out. Macro ADDER_SATURATE_EN clamps sum.
module add_sat_datapath
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl
);
    localparam int NS = WIDTH / 4;

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] raw;
    logic [NS:0]      c;

    // Subtract is a + ~b + 1; the +1 enters as the first slice carry-in.
    assign bb   = sub ? ~b : b;
    assign g    = a & bb;
    assign p    = a ^ bb;
    assign c[0] = sub;

    for (genvar s = 0; s < NS; s++) begin : g_slice
        logic [3:0] gs;
        logic [3:0] ps;
        logic [3:0] cs;

        assign gs    = g[4*s +: 4];
        assign ps    = p[4*s +: 4];
        assign cs[0] = c[s];
        assign cs[1] = gs[0] | (ps[0] & c[s]);
        assign cs[2] = gs[1] | (ps[1] & gs[0])
                     | (ps[1] & ps[0] & c[s]);
        assign cs[3] = gs[2] | (ps[2] & gs[1])
                     | (ps[2] & ps[1] & gs[0])
                     | (ps[2] & ps[1] & ps[0] & c[s]);
        assign c[s+1] = gs[3] | (ps[3] & gs[2])
                      | (ps[3] & ps[2] & gs[1])
                      | (ps[3] & ps[2] & ps[1] & gs[0])
                      | (ps[3] & ps[2] & ps[1] & ps[0] & c[s]);
        assign raw[4*s +: 4] = ps ^ cs;
    end

    assign cout = c[NS];
    assign ovfl = (a[WIDTH-1] == bb[WIDTH-1])
                & (raw[WIDTH-1] != a[WIDTH-1]);

`ifdef ADDER_SATURATE_EN
    localparam logic [WIDTH-1:0] POS_LIM = WIDTH'(SAT_POS(WIDTH));
    localparam logic [WIDTH-1:0] NEG_LIM = WIDTH'(SAT_NEG(WIDTH));

    // Overflow direction follows the sign of a (both operands share it).
    assign sum = !ovfl      ? raw
               : a[WIDTH-1] ? NEG_LIM
               :              POS_LIM;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath with a 1-entry result slot.
// Ports: clk, rst (async high), bus (slave modport). Macro: ADDER_SATURATE_EN.
module adder_share_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int NUM_REQ = REQ_N,
    parameter int WIDTH   = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_share_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [IDW-1:0]     ptr;
    adder_rsp_t         rsp_q;

    logic               slot_free;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gidx;
    logic               found;
    logic [IDW:0]       scan;
    logic               accept;
    logic [IDW-1:0]     ptr_nxt;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_sub;
    logic [WIDTH-1:0]   dp_sum;
    logic               dp_cout;
    logic               dp_ovfl;

    assign slot_free = (state == EMPTY) | bus.rsp_ready;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NUM_REQ)) begin
                scan = scan - (IDW+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                gidx  = scan[IDW-1:0];
            end
        end
        if (found && slot_free && !rst) begin
            gnt[gidx] = 1'b1;
        end
    end

    assign accept        = |gnt;
    assign bus.req_ready = gnt;
    assign ptr_nxt       = (gidx == IDW'(NUM_REQ - 1))
                         ? '0 : gidx + 1'b1;

    assign op_a   = bus.req_a[gidx*WIDTH +: WIDTH];
    assign op_b   = bus.req_b[gidx*WIDTH +: WIDTH];
    assign op_sub = bus.req_sub[gidx];

    add_sat_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .sum  (dp_sum),
        .cout (dp_cout),
        .ovfl (dp_ovfl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ptr   <= '0;
            rsp_q <= '0;
        end else begin
            if (accept) begin
                state      <= FULL;
                ptr        <= ptr_nxt;
                rsp_q.sum  <= dp_sum;
                rsp_q.id   <= gidx;
                rsp_q.cout <= dp_cout;
                rsp_q.ovfl <= dp_ovfl;
            end else if (bus.rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_sum   = rsp_q.sum;
    assign bus.rsp_id    = rsp_q.id;
    assign bus.rsp_cout  = rsp_q.cout;
    assign bus.rsp_ovfl  = rsp_q.ovfl;

endmodule
